// File: rtl/display_controller.sv
// Rotates P1 label, P1 score, P2 label, P2 score onto one 2-digit display, each for a fixed dwell.
// Outputs are a zero-latency combinational decode of the phase and the live score inputs; there is no backpressure.
module display_controller #(
   parameter int LABEL_CYC = 1000,
   parameter int SCORE_CYC = 3000,
   parameter bit BLANK_LZ  = 1'b1
) (
   input  logic       clk_1khz,
   input  logic       rst_i,
   input  logic [3:0] p1_tens_i,
   input  logic [3:0] p1_ones_i,
   input  logic [3:0] p2_tens_i,
   input  logic [3:0] p2_ones_i,
   output logic [3:0] tens_o,
   output logic [3:0] ones_o
);

   localparam int MAX_CYC = (LABEL_CYC > SCORE_CYC) ? LABEL_CYC : SCORE_CYC;
   localparam int CW0     = $clog2(MAX_CYC + 1);
   localparam int CW      = (CW0 < 12) ? 12 : CW0;

   localparam logic [3:0] D_BLANK = 4'hA;
   localparam logic [3:0] D_P     = 4'hB;
   localparam logic [3:0] D_ERR   = 4'hF;

   typedef enum logic [1:0] {P1_LBL, P1_SCR, P2_LBL, P2_SCR} phase_t;

   phase_t        phase, phase_nxt;
   logic [CW-1:0] cnt, cnt_nxt, dwell_last;

   function automatic logic [3:0] score_tens(input logic [3:0] d);
      if (d > 4'd9)
         return D_ERR;
      if (BLANK_LZ && d == 4'd0)
         return D_BLANK;
      return d;
   endfunction

   function automatic logic [3:0] score_ones(input logic [3:0] d);
      return (d > 4'd9) ? D_ERR : d;
   endfunction

   always_ff @(posedge clk_1khz or posedge rst_i) begin
      if (rst_i) begin
         phase <= P1_LBL;
         cnt   <= '0;
      end else begin
         phase <= phase_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      phase_nxt  = phase;
      cnt_nxt    = cnt + CW'(1);
      dwell_last = (phase == P1_LBL || phase == P2_LBL) ? CW'(LABEL_CYC - 1)
                                                        : CW'(SCORE_CYC - 1);
      if (cnt == dwell_last) begin
         cnt_nxt = '0;
         unique case (phase)
            P1_LBL:  phase_nxt = P1_SCR;
            P1_SCR:  phase_nxt = P2_LBL;
            P2_LBL:  phase_nxt = P2_SCR;
            default: phase_nxt = P1_LBL;
         endcase
      end

      // Score inputs go straight through so a mid-phase change shows the same cycle.
      tens_o = D_P;
      ones_o = 4'h1;
      unique case (phase)
         P1_LBL: begin
            tens_o = D_P;
            ones_o = 4'h1;
         end
         P1_SCR: begin
            tens_o = score_tens(p1_tens_i);
            ones_o = score_ones(p1_ones_i);
         end
         P2_LBL: begin
            tens_o = D_P;
            ones_o = 4'h2;
         end
         default: begin
            tens_o = score_tens(p2_tens_i);
            ones_o = score_ones(p2_ones_i);
         end
      endcase
   end

endmodule

// File: tb/tb_display_controller.sv
// Bench for display_controller: a default-dwell instance and a short-dwell, no-blanking instance share stimulus.
// Expected digits come from a time-based model: phase is the edge count since reset modulo the full period.
module tb_display_controller;

   logic       clk_1khz = 1'b0;
   logic       rst_i;
   logic [3:0] p1_tens_i, p1_ones_i, p2_tens_i, p2_ones_i;
   logic [3:0] a_tens, a_ones, b_tens, b_ones;

   int errors = 0;
   int checks = 0;
   int n      = 0;
   bit rnd_en = 1'b0;

   always #5 clk_1khz = ~clk_1khz;

   display_controller u_a (
      .clk_1khz (clk_1khz),
      .rst_i    (rst_i),
      .p1_tens_i(p1_tens_i),
      .p1_ones_i(p1_ones_i),
      .p2_tens_i(p2_tens_i),
      .p2_ones_i(p2_ones_i),
      .tens_o   (a_tens),
      .ones_o   (a_ones)
   );

   display_controller #(.LABEL_CYC(3), .SCORE_CYC(5), .BLANK_LZ(1'b0)) u_b (
      .clk_1khz (clk_1khz),
      .rst_i    (rst_i),
      .p1_tens_i(p1_tens_i),
      .p1_ones_i(p1_ones_i),
      .p2_tens_i(p2_tens_i),
      .p2_ones_i(p2_ones_i),
      .tens_o   (b_tens),
      .ones_o   (b_ones)
   );

   // Edges seen since the last reset; both instances share it.
   always @(posedge clk_1khz or posedge rst_i) begin
      if (rst_i) n <= 0;
      else       n <= n + 1;
   end

   function automatic logic [7:0] score_ref(logic [3:0] t, logic [3:0] o, bit blz);
      logic [3:0] et, eo;
      et = (t > 9) ? 4'hF : ((blz && t == 0) ? 4'hA : t);
      eo = (o > 9) ? 4'hF : o;
      return {et, eo};
   endfunction

   function automatic logic [7:0] model(int cnt, int lbl, int scr, bit blz);
      int t;
      t = cnt % (2 * (lbl + scr));
      if (t < lbl)           return 8'hB1;
      if (t < lbl + scr)     return score_ref(p1_tens_i, p1_ones_i, blz);
      if (t < 2 * lbl + scr) return 8'hB2;
      return score_ref(p2_tens_i, p2_ones_i, blz);
   endfunction

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: edge=%0d got %h expected %h", tag, n, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk_1khz);
      if (rnd_en && $urandom_range(0, 49) == 0) begin
         p1_tens_i = 4'($urandom_range(0, 11));
         p1_ones_i = 4'($urandom_range(0, 11));
         p2_tens_i = 4'($urandom_range(0, 11));
         p2_ones_i = 4'($urandom_range(0, 11));
      end
      #1;
      check("model_a", {a_tens, a_ones}, model(n, 1000, 3000, 1'b1));
      check("model_b", {b_tens, b_ones}, model(n, 3, 5, 1'b0));
   endtask

   initial begin
      rst_i     = 1'b1;
      p1_tens_i = 4'd1;
      p1_ones_i = 4'd2;
      p2_tens_i = 4'd0;
      p2_ones_i = 4'd7;
      #1;
      check("reset_a", {a_tens, a_ones}, 8'hB1);
      check("reset_b", {b_tens, b_ones}, 8'hB1);
      @(negedge clk_1khz);
      rst_i = 1'b0;

      // First full period with fixed scores, plus landmark edges.
      for (int k = 1; k <= 8000; k++) begin
         step();
         case (k)
            999:  check("p1_lbl_end", {a_tens, a_ones}, 8'hB1);
            1000: check("p1_scr_start", {a_tens, a_ones}, 8'h12);
            3999: check("p1_scr_end", {a_tens, a_ones}, 8'h12);
            4000: check("p2_lbl_start", {a_tens, a_ones}, 8'hB2);
            4999: check("p2_lbl_end", {a_tens, a_ones}, 8'hB2);
            5000: check("p2_scr_blank", {a_tens, a_ones}, 8'hA7);
            7999: check("p2_scr_end", {a_tens, a_ones}, 8'hA7);
            8000: check("wrap", {a_tens, a_ones}, 8'hB1);
            13:   check("nolz_b", {b_tens, b_ones}, 8'h07);
            default: ;
         endcase
      end

      // Live input changes in the middle of P1_SCR.
      for (int k = 0; k < 1500; k++) step();
      p1_ones_i = 4'd5;
      #1 check("live_ones", {a_tens, a_ones}, 8'h15);
      p1_tens_i = 4'd12;
      #1 check("bad_tens", {a_tens, a_ones}, 8'hF5);
      p1_tens_i = 4'd0;
      p1_ones_i = 4'd0;
      #1 check("blank_zero", {a_tens, a_ones}, 8'hA0);
      p1_tens_i = 4'd1;
      p1_ones_i = 4'd2;

      // Async reset in the middle of P2_SCR, no clock edge involved.
      for (int k = 0; k < 4500; k++) step();
      check("mid_p2_scr", {a_tens, a_ones}, 8'hA7);
      #1 rst_i = 1'b1;
      #1 check("async_rst", {a_tens, a_ones}, 8'hB1);
      #1 rst_i = 1'b0;
      for (int k = 1; k <= 1000; k++) begin
         step();
         if (k == 999)  check("post_rst_lbl", {a_tens, a_ones}, 8'hB1);
         if (k == 1000) check("post_rst_scr", {a_tens, a_ones}, 8'h12);
      end

      // Long randomized run, well past two full periods.
      rnd_en = 1'b1;
      for (int k = 0; k < 20000; k++) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
